// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: shared types and default constants for the serial deframer.
//   state_t   - FSM state encoding (PARITY only when DEFRAMER_PARITY_EN is defined)
//   DEF_*     - default word width, sync width, sync pattern, frame length
//   cnt_w()   - counter width for a range of n values (at least one bit)
package serial_deframer_pkg;

    localparam int unsigned DEF_WORD_W      = 8;
    localparam int unsigned DEF_SYNC_W      = 8;
    localparam logic [7:0]  DEF_SYNC_PAT    = 8'b1010_0101;
    localparam int unsigned DEF_FRAME_WORDS = 4;

`ifdef DEFRAMER_PARITY_EN
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;
`endif

    // Width needed to count 0..n-1; a range of one still gets one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_deframer_sync.sv
// sync_detect: serial sync-pattern matcher.
//   clk, rst (async, active-low), clear (synchronous flush of the shift register),
//   in (serial bit), match (combinational: register including the current bit equals SYNC_PAT).
module sync_detect #(
    parameter int unsigned       SYNC_W   = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(8'b1010_0101)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in,
    output logic match
);

    logic [SYNC_W-1:0] sr_q;
    logic [SYNC_W-1:0] sr_next;

    // Oldest bit ends up in the MSB, matching the pattern's first-received-bit-in-MSB order.
    assign sr_next = {sr_q[SYNC_W-2:0], in};
    assign match   = (sr_next == SYNC_PAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_next;
        end
    end

endmodule

// File: rtl/serial_deframer.sv
// serial_deframer: hunts for a sync pattern in a serial bit stream, then assembles
// FRAME_WORDS words of WORD_W bits (MSB first) and presents them with valid/ready.
// Optional feature macro: DEFRAMER_PARITY_EN (one even-parity bit after each word).
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   in         - serial bit, one per clock
//   clr_err    - clears the sticky overflow flag
//   out_ready  - downstream accepts the presented word
//   out_data   - assembled word, first-received bit in MSB
//   out_valid  - out_data/out_last/out_perr valid
//   out_last   - word is the last of its frame
//   out_perr   - parity error on this word (0 without DEFRAMER_PARITY_EN)
//   overflow   - sticky: a completed word was dropped
//   locked     - FSM is outside HUNT
module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter int unsigned       WORD_W      = DEF_WORD_W,
    parameter int unsigned       SYNC_W      = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT    = SYNC_W'(DEF_SYNC_PAT),
    parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              clr_err,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_perr,
    output logic              overflow,
    output logic              locked
);

    localparam int unsigned BIT_CW  = cnt_w(WORD_W);
    localparam int unsigned WORD_CW = cnt_w(FRAME_WORDS);

    state_t             state_q;
    state_t             state_d;
    logic [BIT_CW-1:0]  bit_cnt_q;
    logic [WORD_CW-1:0] word_cnt_q;
    logic [WORD_W-1:0]  word_q;

    logic               sync_clear;
    logic               sync_match;
    logic               bit_last_c;
    logic               word_last_c;
    logic [WORD_W-1:0]  shifted_c;
    logic               complete_c;
    logic [WORD_W-1:0]  cmp_data_c;
    logic               drop_c;
`ifdef DEFRAMER_PARITY_EN
    logic               cmp_perr_c;
`endif

    // Sync register is held flushed whenever we are locked, so HUNT always restarts clean.
    assign sync_clear = (state_q != ST_HUNT);

    sync_detect #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .clear (sync_clear),
        .in    (in),
        .match (sync_match)
    );

    assign bit_last_c  = (bit_cnt_q == BIT_CW'(WORD_W - 1));
    assign word_last_c = (word_cnt_q == WORD_CW'(FRAME_WORDS - 1));
    assign shifted_c   = {word_q[WORD_W-2:0], in};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: begin
                if (sync_match) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_last_c) begin
`ifdef DEFRAMER_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = word_last_c ? ST_HUNT : ST_DATA;
`endif
                end
            end
`ifdef DEFRAMER_PARITY_EN
            ST_PARITY: begin
                state_d = word_last_c ? ST_HUNT : ST_DATA;
            end
`endif
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Word-completion decode: which cycle finishes a word and what it carries.
    always_comb begin
        complete_c = 1'b0;
        cmp_data_c = shifted_c;
`ifdef DEFRAMER_PARITY_EN
        cmp_perr_c = 1'b0;
`endif
        case (state_q)
            ST_DATA: begin
`ifndef DEFRAMER_PARITY_EN
                complete_c = bit_last_c;
`endif
            end
`ifdef DEFRAMER_PARITY_EN
            ST_PARITY: begin
                complete_c = 1'b1;
                cmp_data_c = word_q;
                // Even parity: data ones plus parity bit must be even.
                cmp_perr_c = ^{word_q, in};
            end
`endif
            default: begin
            end
        endcase
    end

    // Bit/word counters and word shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            if (state_q == ST_HUNT) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                word_q     <= '0;
            end
            if (state_q == ST_DATA) begin
                word_q    <= shifted_c;
                bit_cnt_q <= bit_last_c ? '0 : bit_cnt_q + BIT_CW'(1);
            end
            if (complete_c) begin
                word_cnt_q <= word_last_c ? '0 : word_cnt_q + WORD_CW'(1);
            end
        end
    end

    // A completed word is dropped only if the held word is not leaving this same cycle.
    assign drop_c = complete_c && out_valid && !out_ready;

    // Output holding register and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (complete_c && !drop_c) begin
                out_data  <= cmp_data_c;
                out_last  <= word_last_c;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            locked <= (state_d != ST_HUNT);
        end
    end

`ifdef DEFRAMER_PARITY_EN
    // Parity flag travels with the word it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_perr <= 1'b0;
        end else if (complete_c && !drop_c) begin
            out_perr <= cmp_perr_c;
        end
    end
`else
    assign out_perr = 1'b0;
`endif

endmodule
